// File: rtl/reg_display_sequencer.sv
// reg_display_sequencer
// Walks the CPU register file one register per text line. Each line has
// 12 glyphs: 'R', a two-digit hex index, a space, then eight hex nibbles
// of the register value. Every glyph is handed to the renderer over a
// valid/ready handshake, together with its cell coordinates.

module reg_display_sequencer #(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 9,
    parameter int READ_LATENCY = 1,
    parameter int X0           = 10,
    parameter int Y0           = 10,
    parameter int COL_PITCH    = 9,
    parameter int ROW_PITCH    = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       reg_value,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [5:0]        char_code,
    output logic [9:0]        char_x,
    output logic [9:0]        char_y,
    output logic              busy,
    output logic              finished_register,
    output logic              frame_done
);

    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [5:0] CODE_R     = 6'd52;
    localparam logic [5:0] CODE_SPACE = 6'd63;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EMIT,
        NEXT
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [7:0]          r_idx;
    logic [3:0]          r_col;
    logic [WAIT_W-1:0]   r_wait;
    logic [31:0]         r_value;

    logic                w_readDone;
    logic                w_lastCol;
    logic                w_lastReg;
    logic                w_handshake;
    logic [5:0]          w_glyph;
    logic [9:0]          w_cellX;
    logic [9:0]          w_cellY;

    assign w_readDone  = (r_wait == WAIT_W'(READ_LATENCY - 1));
    assign w_lastCol   = (r_col == 4'd11);
    assign w_lastReg   = (r_idx == 8'(NUM_REGS - 1));
    assign w_handshake = (r_state == EMIT) && char_ready;

    // Cell position: wraps modulo 1024, matching the 10-bit pixel bus.
    assign w_cellX = 10'(X0) + 10'(r_col) * 10'(COL_PITCH);
    assign w_cellY = 10'(Y0) + 10'(r_idx) * 10'(ROW_PITCH);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath: read-wait counter, value latch, column and register index.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx   <= '0;
            r_col   <= '0;
            r_wait  <= '0;
            r_value <= '0;
        end else begin
            case (r_state)
                READ: begin
                    if (w_readDone) begin
                        r_value <= reg_value;
                        r_wait  <= '0;
                        r_col   <= '0;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                EMIT: begin
                    if (w_handshake) begin
                        r_col <= w_lastCol ? 4'd0 : r_col + 4'd1;
                    end
                end
                NEXT: begin
                    r_idx <= w_lastReg ? 8'd0 : r_idx + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decision.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (start) w_nextState = READ;
            READ: if (w_readDone) w_nextState = EMIT;
            EMIT: if (w_handshake && w_lastCol) w_nextState = NEXT;
            NEXT: w_nextState = (w_lastReg && !continuous) ? IDLE : READ;
            default: w_nextState = IDLE;
        endcase
    end

    // Glyph code for the current column of the current line.
    always_comb begin
        w_glyph = 6'd0;
        case (r_col)
            4'd0:    w_glyph = CODE_R;
            4'd1:    w_glyph = {2'b00, r_idx[7:4]};
            4'd2:    w_glyph = {2'b00, r_idx[3:0]};
            4'd3:    w_glyph = CODE_SPACE;
            4'd4:    w_glyph = {2'b00, r_value[31:28]};
            4'd5:    w_glyph = {2'b00, r_value[27:24]};
            4'd6:    w_glyph = {2'b00, r_value[23:20]};
            4'd7:    w_glyph = {2'b00, r_value[19:16]};
            4'd8:    w_glyph = {2'b00, r_value[15:12]};
            4'd9:    w_glyph = {2'b00, r_value[11:8]};
            4'd10:   w_glyph = {2'b00, r_value[7:4]};
            4'd11:   w_glyph = {2'b00, r_value[3:0]};
            default: w_glyph = 6'd0;
        endcase
    end

    // Outputs: character bus only live in EMIT, line/frame pulses in NEXT.
    always_comb begin
        reg_addr          = ADDR_W'(r_idx);
        busy              = (r_state != IDLE);
        char_valid        = 1'b0;
        char_code         = 6'd0;
        char_x            = 10'd0;
        char_y            = 10'd0;
        finished_register = 1'b0;
        frame_done        = 1'b0;
        case (r_state)
            EMIT: begin
                char_valid = 1'b1;
                char_code  = w_glyph;
                char_x     = w_cellX;
                char_y     = w_cellY;
            end
            NEXT: begin
                finished_register = 1'b1;
                frame_done        = w_lastReg;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_display_sequencer.sv
// Testbench for reg_display_sequencer.
// Instance A uses the default parameters (8 registers, read latency 1).
// Instance B displays a single register with a read latency of 3.

module tb_reg_display_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Instance A signals
    logic        startA = 1'b0;
    logic        contA = 1'b0;
    logic        readyA = 1'b0;
    logic        valueMode = 1'b0;
    logic [31:0] valueManualA = 32'h0;
    logic [31:0] valueA;
    logic [8:0]  addrA;
    logic        validA;
    logic [5:0]  codeA;
    logic [9:0]  xA;
    logic [9:0]  yA;
    logic        busyA;
    logic        finA;
    logic        doneA;

    // Instance B signals
    logic        startB = 1'b0;
    logic        contB = 1'b0;
    logic        readyB = 1'b0;
    logic [31:0] valueB = 32'h0;
    logic [8:0]  addrB;
    logic        validB;
    logic [5:0]  codeB;
    logic [9:0]  xB;
    logic [9:0]  yB;
    logic        busyB;
    logic        finB;
    logic        doneB;

    // Register file model for A: register n holds n repeated in every nibble.
    assign valueA = valueMode ? (32'(addrA) * 32'h11111111) : valueManualA;

    reg_display_sequencer dutA (
        .clock             (clock),
        .reset             (reset),
        .start             (startA),
        .continuous        (contA),
        .reg_addr          (addrA),
        .reg_value         (valueA),
        .char_valid        (validA),
        .char_ready        (readyA),
        .char_code         (codeA),
        .char_x            (xA),
        .char_y            (yA),
        .busy              (busyA),
        .finished_register (finA),
        .frame_done        (doneA)
    );

    reg_display_sequencer #(
        .NUM_REGS     (1),
        .READ_LATENCY (3)
    ) dutB (
        .clock             (clock),
        .reset             (reset),
        .start             (startB),
        .continuous        (contB),
        .reg_addr          (addrB),
        .reg_value         (valueB),
        .char_valid        (validB),
        .char_ready        (readyB),
        .char_code         (codeB),
        .char_x            (xB),
        .char_y            (yB),
        .busy              (busyB),
        .finished_register (finB),
        .frame_done        (doneB)
    );

    typedef struct {
        logic ready;
        logic expValid;
        int   expCode;
        int   expX;
        int   expY;
        int   expAddr;
        logic expFin;
        logic expBusy;
    } vec_t;

    vec_t vecs[21];

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives the renderer ready for A and advances to the next sampling point.
    task automatic applyStimulus(input logic readyV);
        readyA = readyV;
        @(negedge clock);
    endtask

    // Synchronous reset across one rising edge.
    task automatic applyReset();
        @(negedge clock);
        reset  = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Reference glyph for one column of a line.
    function automatic int expCodeOf(input int idx, input int col, input logic [31:0] v);
        case (col)
            0:       return 52;
            1:       return (idx >> 4) & 15;
            2:       return idx & 15;
            3:       return 63;
            default: return int'((v >> (4 * (11 - col))) & 32'hF);
        endcase
    endfunction

    function automatic logic [31:0] patB(input int n);
        return 32'h89ABCDEF + 32'(n) * 32'h01234567;
    endfunction

    // Runs one full frame on A with a scoreboard tracking the expected line/column.
    task automatic runFrameA(input bit randomReady, input bit pokeStart);
        int expIdx = 0;
        int expCol = 0;
        int lineHs = 0;
        int finCount = 0;
        int doneCount = 0;
        int busyCycles = 0;
        bit finishedFrame = 1'b0;
        startA = 1'b1;
        readyA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        for (int cyc = 0; cyc < 2000 && !finishedFrame; cyc++) begin
            if (busyA) busyCycles++;
            if (validA) begin
                checkOutput("frameCode", 32'(codeA),
                            32'(expCodeOf(expIdx, expCol, 32'(expIdx) * 32'h11111111)));
                checkOutput("frameX", 32'(xA), 32'(10'(10 + expCol * 9)));
                checkOutput("frameY", 32'(yA), 32'(10'(10 + expIdx * 15)));
            end
            if (finA) begin
                finCount++;
                checkOutput("lineHandshakes", 32'(lineHs), 32'd12);
                checkOutput("doneOnLast", 32'(doneA), 32'(expIdx == 7));
                if (doneA) begin
                    doneCount++;
                    checkOutput("finCountAtDone", 32'(finCount), 32'd8);
                    finishedFrame = 1'b1;
                end
                lineHs = 0;
                expCol = 0;
                expIdx++;
            end
            readyA = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            startA = (pokeStart && !finishedFrame) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (validA && readyA) begin
                lineHs++;
                expCol++;
            end
            if (!finishedFrame) @(negedge clock);
        end
        checkOutput("frameCompleted", 32'(finishedFrame), 32'd1);
        checkOutput("doneCount", 32'(doneCount), 32'd1);
        if (!randomReady) checkOutput("busyCycles", 32'(busyCycles), 32'd112);
        @(negedge clock);
        checkOutput("busyAfterFrame", 32'(busyA), 32'd0);
    endtask

    initial begin
        int ei;
        int ec;
        bit found;

        // Line 0 of A with value DEADBEEF and a stalling renderer, then line 1 begins.
        vecs[0]  = '{1'b1, 1'b0,  0,   0,  0, 0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 52,  10, 10, 0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1,  0,  19, 10, 0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1,  0,  19, 10, 0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1,  0,  28, 10, 0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 63,  37, 10, 0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 63,  37, 10, 0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 63,  37, 10, 0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 13,  46, 10, 0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 14,  55, 10, 0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 10,  64, 10, 0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 10,  64, 10, 0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 13,  73, 10, 0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 11,  82, 10, 0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 14,  91, 10, 0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 14, 100, 10, 0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 14, 100, 10, 0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 15, 109, 10, 0, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b0,  0,   0,  0, 0, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b0,  0,   0,  0, 1, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 1'b1, 52,  10, 25, 1, 1'b0, 1'b1};

        // Reset state of every output.
        applyReset();
        checkOutput("rstAddr", 32'(addrA), 32'd0);
        checkOutput("rstValid", 32'(validA), 32'd0);
        checkOutput("rstCode", 32'(codeA), 32'd0);
        checkOutput("rstX", 32'(xA), 32'd0);
        checkOutput("rstY", 32'(yA), 32'd0);
        checkOutput("rstBusy", 32'(busyA), 32'd0);
        checkOutput("rstFin", 32'(finA), 32'd0);
        checkOutput("rstDone", 32'(doneA), 32'd0);

        // Table-driven line with a stalling renderer.
        valueMode    = 1'b0;
        valueManualA = 32'hDEADBEEF;
        startA       = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        for (int i = 0; i < 21; i++) begin
            checkOutput($sformatf("vec%0d.valid", i), 32'(validA), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d.code", i), 32'(codeA), 32'(vecs[i].expCode));
            checkOutput($sformatf("vec%0d.x", i), 32'(xA), 32'(vecs[i].expX));
            checkOutput($sformatf("vec%0d.y", i), 32'(yA), 32'(vecs[i].expY));
            checkOutput($sformatf("vec%0d.addr", i), 32'(addrA), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d.fin", i), 32'(finA), 32'(vecs[i].expFin));
            checkOutput($sformatf("vec%0d.busy", i), 32'(busyA), 32'(vecs[i].expBusy));
            applyStimulus(vecs[i].ready);
        end

        // Full eight-register frame, ready held high, start poked while busy.
        applyReset();
        valueMode = 1'b1;
        runFrameA(1'b0, 1'b1);

        // Full frame with a randomly stalling renderer.
        runFrameA(1'b1, 1'b0);

        // Reset in the middle of register 3, column 5.
        applyReset();
        found  = 1'b0;
        ei     = 0;
        ec     = 0;
        startA = 1'b1;
        readyA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (finA) begin
                ei++;
                ec = 0;
            end
            if (validA && ei == 3 && ec == 5) begin
                found = 1'b1;
            end else begin
                if (validA) ec++;
                @(negedge clock);
            end
        end
        checkOutput("midFrameReached", 32'(found), 32'd1);
        checkOutput("midCode", 32'(codeA), 32'd3);
        checkOutput("midX", 32'(xA), 32'd55);
        checkOutput("midY", 32'(yA), 32'd55);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abortValid", 32'(validA), 32'd0);
        checkOutput("abortBusy", 32'(busyA), 32'd0);
        checkOutput("abortAddr", 32'(addrA), 32'd0);
        checkOutput("abortCode", 32'(codeA), 32'd0);
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        checkOutput("restartAddr", 32'(addrA), 32'd0);
        checkOutput("restartBusy", 32'(busyA), 32'd1);
        @(negedge clock);
        checkOutput("restartValid", 32'(validA), 32'd1);
        checkOutput("restartCode", 32'(codeA), 32'd52);
        checkOutput("restartX", 32'(xA), 32'd10);
        checkOutput("restartY", 32'(yA), 32'd10);

        // Continuous mode: a frame restarts immediately after frame_done.
        applyReset();
        contA  = 1'b1;
        readyA = 1'b1;
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        for (int c = 0; c < 300 && !doneA; c++) @(negedge clock);
        checkOutput("contDone", 32'(doneA), 32'd1);
        @(negedge clock);
        checkOutput("contBusy", 32'(busyA), 32'd1);
        checkOutput("contAddr", 32'(addrA), 32'd0);
        checkOutput("contValid", 32'(validA), 32'd0);
        @(negedge clock);
        checkOutput("contCode", 32'(codeA), 32'd52);
        checkOutput("contY", 32'(yA), 32'd10);
        contA = 1'b0;
        for (int c = 0; c < 300 && !doneA; c++) @(negedge clock);
        checkOutput("contDone2", 32'(doneA), 32'd1);
        @(negedge clock);
        checkOutput("contStop", 32'(busyA), 32'd0);

        // Instance B: read latency 3 with a value changing every cycle.
        applyReset();
        readyB = 1'b1;
        startB = 1'b1;
        valueB = patB(0);
        @(negedge clock);
        startB = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            checkOutput($sformatf("bRead%0d.addr", n), 32'(addrB), 32'd0);
            checkOutput($sformatf("bRead%0d.valid", n), 32'(validB), 32'd0);
            checkOutput($sformatf("bRead%0d.busy", n), 32'(busyB), 32'd1);
            valueB = patB(n);
            @(negedge clock);
        end
        for (int c = 0; c < 12; c++) begin
            checkOutput($sformatf("bCol%0d.valid", c), 32'(validB), 32'd1);
            checkOutput($sformatf("bCol%0d.code", c), 32'(codeB), 32'(expCodeOf(0, c, patB(3))));
            checkOutput($sformatf("bCol%0d.x", c), 32'(xB), 32'(10 + c * 9));
            checkOutput($sformatf("bCol%0d.y", c), 32'(yB), 32'd10);
            valueB = patB(4 + c);
            @(negedge clock);
        end
        checkOutput("bFin", 32'(finB), 32'd1);
        checkOutput("bDone", 32'(doneB), 32'd1);
        checkOutput("bNextValid", 32'(validB), 32'd0);
        @(negedge clock);
        checkOutput("bIdle", 32'(busyB), 32'd0);
        checkOutput("bNoFin", 32'(finB), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_display_sequencer.md
Name: reg_display_sequencer

Overview:
- Controller that walks the CPU register file and schedules text rendering of each register on the VGA display, one 12-character line per register.
- Issues register-read addresses and latches each 32-bit value.
- Converts each line to glyph codes (R, 2-digit hex index, space, 8 hex nibbles) with cell coordinates.
- Hands each character to the glyph renderer over a valid/ready handshake.

Parameters:
NUM_REGS, 8, registers displayed per frame (1..256)
ADDR_W, 9, width of reg_addr
READ_LATENCY, 1, cycles from reg_addr valid to reg_value valid (>=1)
X0, 10, pixel x of column 0
Y0, 10, pixel y of row 0
COL_PITCH, 9, pixels between character columns
ROW_PITCH, 15, pixels between register rows

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  begin one frame; sampled only in IDLE
continuous  input  1  when 1, restart automatically after frame_done
reg_addr  output  ADDR_W  register file read address (zero-extended index)
reg_value  input  32  register read data
char_valid  output  1  char_code/char_x/char_y valid
char_ready  input  1  renderer accepts the character
char_code  output  6  glyph code: 0-15 hex digit, 52 'R', 63 space
char_x  output  10  pixel x of cell top-left
char_y  output  10  pixel y of cell top-left
busy  output  1  high in any state except IDLE
finished_register  output  1  one-cycle pulse when a register line completes
frame_done  output  1  one-cycle pulse when the last register line completes

Behaviour:
- Reset (synchronous, clock edge with reset=1): state=IDLE, idx=0, col=0, wait counter=0, latched value=0. All outputs 0: reg_addr=0, char_valid=0, char_code=0, char_x=0, char_y=0, busy=0, finished_register=0, frame_done=0. Reset mid-frame aborts immediately and discards the pending char with no handshake.
- States: IDLE, READ, EMIT, NEXT.
- IDLE -> READ when start=1. start is ignored in any other state.
- READ:
  - reg_addr=idx, held stable for READ_LATENCY cycles.
  - reg_value is sampled on the edge ending the READ_LATENCY-th READ cycle; go to EMIT with col=0.
  - First char_valid is high in the cycle after edge k+READ_LATENCY, where k is the edge that sampled start.
- EMIT:
  - char_valid=1. char_code/char_x/char_y stay stable until char_valid && char_ready at a clock edge; char_valid never drops without a handshake.
  - Each handshake increments col. A handshake at col=11 goes to NEXT.
  - Zero-bubble: a new character is presented the cycle after each handshake.
- Column map:
  - col0: code 52.
  - col1: idx[7:4].
  - col2: idx[3:0].
  - col3: code 63.
  - col4..col11: latched value nibbles [31:28] down to [3:0].
- Coordinates: char_x = X0 + col*COL_PITCH; char_y = Y0 + idx*ROW_PITCH. Computed 10-bit, truncating.
- NEXT (one cycle): finished_register=1.
  - If idx==NUM_REGS-1: frame_done=1 in the same cycle, idx wraps to 0, then READ if continuous=1, else IDLE.
  - Otherwise idx+1, then READ.
- reg_value changes outside the sample edge have no effect on emitted codes.
- char_ready while char_valid=0 is ignored.
- Per-line cost with char_ready tied high: READ_LATENCY + 12 + 1 cycles.

Test Plan:
- Reset then start=1 one cycle, NUM_REGS=1, READ_LATENCY=1, reg_value=32'hDEADBEEF, char_ready=1 -> reg_addr=0 in READ. Codes 52,0,0,63,13,14,10,13,11,14,14,15 on consecutive cycles. char_x=10,19,...,109; char_y=10. finished_register and frame_done pulse together once; busy falls next cycle.
- NUM_REGS=8, reg_value=idx*32'h11111111 -> eight lines, char_y=10,25,...,115. finished_register 8 pulses; frame_done only on the 8th; 8*14=112 cycles of busy.
- char_ready toggling 1-0-1 pseudo-randomly -> outputs held constant while char_valid=1 and char_ready=0. Exactly 12 handshakes per line; no code skipped or duplicated.
- READ_LATENCY=3, reg_value changes every cycle -> emitted nibbles equal the value present at the edge 3 cycles after reg_addr was set; reg_addr stable for all 3 READ cycles.
- continuous=1 with start pulsed once -> after frame_done, READ with reg_addr=0 the next cycle. start pulses while busy change nothing.
- reset asserted mid-EMIT at col=5, idx=3 -> next cycle char_valid=0, busy=0, reg_addr=0. A later start begins at idx=0, col=0.
